// File: rtl/fsab_dma_arbiter_pkg.sv
// FSAB bus constants shared by the DMA request arbiter: field widths,
// request mode encoding and the credit pool size of the request port.
package fsab_dma_arbiter_pkg;

    localparam int FSAB_REQ_HI     = 0;
    localparam int FSAB_DID_HI     = 3;
    localparam int FSAB_ADDR_HI    = 30;
    localparam int FSAB_LEN_HI     = 2;
    localparam int FSAB_CREDITS_HI = 2;

    localparam logic [FSAB_REQ_HI:0]     FSAB_READ            = 1'b0;
    localparam logic [FSAB_REQ_HI:0]     FSAB_WRITE           = 1'b1;
    localparam logic [FSAB_CREDITS_HI:0] FSAB_INITIAL_CREDITS = 3'd4;

    // Width of an index into n requesters (never narrower than one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsab_dma_arbiter_chk.sv
// Protocol checker for the arbiter: credit counter bounds, requester
// completion bookkeeping and one-hot acknowledge.
module fsab_dma_arbiter_chk #(
    parameter int            N_REQ        = 4,
    parameter int            CW           = 3,
    parameter logic [CW-1:0] INIT_CREDITS = 3'd4
) (
    input logic             clk,
    input logic             rst_b,
    input logic [CW-1:0]    credits,
    input logic             fsabo_valid,
    input logic             fsabo_credit,
    input logic [N_REQ-1:0] req_done,
    input logic [N_REQ-1:0] outst_zero,
    input logic [N_REQ-1:0] req_ack
);

    // An issue is only ever launched with at least one credit in hand
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_b)
        fsabo_valid |-> (credits != {CW{1'b0}}));

    // The bus must never return more credits than it was given
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_b)
        (int'(credits) + int'(fsabo_credit) - int'(fsabo_valid)) <= int'(INIT_CREDITS));

    // A completion without a read in flight points at a broken requester
    a_done_has_outst: assert property (@(posedge clk) disable iff (!rst_b)
        (req_done & outst_zero) == {N_REQ{1'b0}});

    // At most one requester is accepted per cycle
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_b)
        $onehot0(req_ack));

endmodule

// File: rtl/fsab_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible requester strictly
// after ptr (wrapping) wins. Returns a one-hot grant, its index and a hit flag.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         any
);

    logic [W-1:0] cand;
    logic         hit;

    // Walk the N slots after ptr in order; the first eligible slot latches the result
    always_comb begin
        grant = {N{1'b0}};
        index = {W{1'b0}};
        any   = 1'b0;
        cand  = {W{1'b0}};
        hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand        = W'((int'(ptr) + k) % N);
            hit         = !any && eligible[cand];
            grant[cand] = grant[cand] | hit;
            index       = hit ? cand : index;
            any         = any | hit;
        end
    end

endmodule

// File: rtl/fsab_dma_arbiter.sv
// fsab_dma_arbiter: shares one FSAB read request port among N_REQ DMA engines.
// Round-robin arbitration, owns the FSAB credit counter, limits reads in flight
// per requester and tags each request with subdid = SUBDID_BASE + index.
// Optional: define FSAB_ARB_STATS_EN to add saturating per-requester
// grant/stall counters (stat_grants, stat_stalls); arbitration is unchanged.
module fsab_dma_arbiter
    import fsab_dma_arbiter_pkg::*;
#(
    parameter int                        N_REQ        = 4,
    parameter logic [FSAB_DID_HI:0]      FSAB_DID     = 4'hF,
    parameter logic [FSAB_DID_HI:0]      SUBDID_BASE  = 4'h0,
    parameter int                        MAX_OUTST    = 2,
    parameter logic [FSAB_CREDITS_HI:0]  INIT_CREDITS = FSAB_INITIAL_CREDITS
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*(FSAB_ADDR_HI+1)-1:0]  req_addr,
    input  logic [N_REQ*(FSAB_LEN_HI+1)-1:0]   req_len,
    output logic [N_REQ-1:0]                   req_ack,
    input  logic [N_REQ-1:0]                   req_done,
    output logic                               fsabo_valid,
    output logic [FSAB_REQ_HI:0]               fsabo_mode,
    output logic [FSAB_DID_HI:0]               fsabo_did,
    output logic [FSAB_DID_HI:0]               fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]              fsabo_addr,
    output logic [FSAB_LEN_HI:0]               fsabo_len,
    input  logic                               fsabo_credit
`ifdef FSAB_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]                stat_grants,
    output logic [N_REQ*16-1:0]                stat_stalls
`endif
);

    localparam int PW = ptr_width(N_REQ);
    localparam int AW = FSAB_ADDR_HI + 1;
    localparam int LW = FSAB_LEN_HI + 1;
    localparam int CW = FSAB_CREDITS_HI + 1;
    localparam int DW = FSAB_DID_HI + 1;

    logic [CW-1:0]    credits;
    logic [PW-1:0]    rr_ptr;
    logic [2:0]       outst     [N_REQ];
    logic [2:0]       outst_nxt [N_REQ];
    logic [N_REQ-1:0] outst_zero;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant_oh;
    logic [PW-1:0]    grant_idx;
    logic             grant_any;
    logic             cred_ok;
    logic             do_grant;
    logic [AW-1:0]    sel_addr;
    logic [LW-1:0]    sel_len;

    // A requester competes only while it has room for another read in flight
    always_comb begin
        eligible   = {N_REQ{1'b0}};
        outst_zero = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i]   = req_valid[i] && (outst[i] < 3'(MAX_OUTST));
            outst_zero[i] = (outst[i] == 3'd0);
        end
    end

    rr_pick #(.N(N_REQ), .W(PW)) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant_oh),
        .index    (grant_idx),
        .any      (grant_any)
    );

    // Keep one credit in reserve for the issue already on the bus this cycle
    always_comb begin
        cred_ok  = credits > {{(CW-1){1'b0}}, fsabo_valid};
        do_grant = rst_b && cred_ok && grant_any;
        req_ack  = do_grant ? grant_oh : {N_REQ{1'b0}};
    end

    // Select the winner's address/length slice with a one-hot AND-OR mux
    always_comb begin
        sel_addr = {AW{1'b0}};
        sel_len  = {LW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr = sel_addr | (grant_oh[i] ? req_addr[i*AW +: AW] : {AW{1'b0}});
            sel_len  = sel_len  | (grant_oh[i] ? req_len[i*LW +: LW]  : {LW{1'b0}});
        end
    end

    // Grant and completion in the same cycle cancel; a stray completion is dropped
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_nxt[i] = outst[i]
                         + {2'b00, req_ack[i]}
                         - {2'b00, (req_done[i] && !outst_zero[i])};
        end
    end

    // Issue register, credit counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fsabo_valid  <= 1'b0;
            fsabo_mode   <= {(FSAB_REQ_HI+1){1'b0}};
            fsabo_did    <= {DW{1'b0}};
            fsabo_subdid <= {DW{1'b0}};
            fsabo_addr   <= {AW{1'b0}};
            fsabo_len    <= {LW{1'b0}};
            credits      <= INIT_CREDITS;
            rr_ptr       <= PW'(N_REQ - 1);
        end else begin
            fsabo_valid <= do_grant;
            credits     <= credits + CW'(fsabo_credit) - CW'(fsabo_valid);
            if (do_grant) begin
                fsabo_mode   <= FSAB_READ;
                fsabo_did    <= FSAB_DID;
                fsabo_subdid <= SUBDID_BASE + DW'(grant_idx);
                fsabo_addr   <= sel_addr;
                fsabo_len    <= sel_len;
                rr_ptr       <= grant_idx;
            end
        end
    end

    // Per-requester count of reads in flight
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < N_REQ; i++) begin
                outst[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                outst[i] <= outst_nxt[i];
            end
        end
    end

`ifdef FSAB_ARB_STATS_EN
    // Saturating grant and stall counters per requester
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stat_grants <= {(N_REQ*16){1'b0}};
            stat_stalls <= {(N_REQ*16){1'b0}};
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ack[i] && (stat_grants[i*16 +: 16] != 16'hFFFF)) begin
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
                end
                if (req_valid[i] && !req_ack[i] && (stat_stalls[i*16 +: 16] != 16'hFFFF)) begin
                    stat_stalls[i*16 +: 16] <= stat_stalls[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

    fsab_dma_arbiter_chk #(
        .N_REQ        (N_REQ),
        .CW           (CW),
        .INIT_CREDITS (INIT_CREDITS)
    ) u_chk (
        .clk          (clk),
        .rst_b        (rst_b),
        .credits      (credits),
        .fsabo_valid  (fsabo_valid),
        .fsabo_credit (fsabo_credit),
        .req_done     (req_done),
        .outst_zero   (outst_zero),
        .req_ack      (req_ack)
    );

endmodule

// File: tb/tb_fsab_dma_arbiter.sv
// Self-checking bench for fsab_dma_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_fsab_dma_arbiter;
    import fsab_dma_arbiter_pkg::*;

    localparam int         N     = 4;
    localparam logic [3:0] DID   = 4'h5;
    localparam logic [3:0] SBASE = 4'h8;
    localparam int         MAXO  = 2;
    localparam int         INITC = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  rv, rd;
    logic        cr;
    logic [30:0] ad [4];
    logic [2:0]  ln [4];
    logic [123:0] req_addr;
    logic [11:0]  req_len;
    logic [3:0]  req_ack;
    logic        fsabo_valid;
    logic [0:0]  fsabo_mode;
    logic [3:0]  fsabo_did, fsabo_subdid;
    logic [30:0] fsabo_addr;
    logic [2:0]  fsabo_len;
`ifdef FSAB_ARB_STATS_EN
    logic [63:0] stat_grants, stat_stalls;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cred, m_ptr;
    int          m_outst [4];
    bit          m_valid;
    logic [30:0] m_addr;
    logic [2:0]  m_len;
    logic [3:0]  m_sub, m_did;
    int          m_sg [4];
    int          m_ss [4];

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*31 +: 31] = ad[i];
            req_len[i*3 +: 3]    = ln[i];
        end
    end

    fsab_dma_arbiter #(
        .N_REQ(N), .FSAB_DID(DID), .SUBDID_BASE(SBASE), .MAX_OUTST(MAXO), .INIT_CREDITS(3'd4)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(rv), .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .req_done(rd), .fsabo_valid(fsabo_valid), .fsabo_mode(fsabo_mode),
        .fsabo_did(fsabo_did), .fsabo_subdid(fsabo_subdid), .fsabo_addr(fsabo_addr),
        .fsabo_len(fsabo_len), .fsabo_credit(cr)
`ifdef FSAB_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    task automatic model_reset();
        m_cred = INITC; m_ptr = N - 1; m_valid = 0;
        m_addr = '0; m_len = '0; m_sub = '0; m_did = '0;
        for (int i = 0; i < 4; i++) begin
            m_outst[i] = 0; m_sg[i] = 0; m_ss[i] = 0;
        end
    endtask

    // Which requester the spec's rules grant this cycle (-1 for none)
    task automatic model_eval(output int g);
        g = -1;
        if (m_cred > (m_valid ? 1 : 0)) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && rv[c] && m_outst[c] < MAXO) g = c;
            end
        end
    endtask

    // Advance the model across one clock edge given the chosen grant
    task automatic model_clock(input int g);
        m_cred = m_cred + int'(cr) - (m_valid ? 1 : 0);
        for (int i = 0; i < 4; i++) begin
            int pre;
            pre = m_outst[i];
            m_outst[i] = pre + ((g == i) ? 1 : 0) - ((rd[i] && pre > 0) ? 1 : 0);
            if (g == i && m_sg[i] < 65535) m_sg[i]++;
            if (rv[i] && g != i && m_ss[i] < 65535) m_ss[i]++;
        end
        if (g >= 0) begin
            m_valid = 1; m_ptr = g; m_addr = ad[g]; m_len = ln[g];
            m_sub = SBASE + 4'(g); m_did = DID;
        end else begin
            m_valid = 0;
        end
    endtask

    function automatic logic [3:0] ack_vec(input int g);
        logic [3:0] v;
        v = 4'b0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic bit outs_ok();
        return fsabo_valid === m_valid && fsabo_addr === m_addr && fsabo_len === m_len &&
               fsabo_subdid === m_sub && fsabo_did === m_did && fsabo_mode === FSAB_READ;
    endfunction

    task automatic test_reset();
        rst_b = 1'b0; rv = 4'b1111; rd = '0; cr = 1'b0;
        for (int i = 0; i < 4; i++) begin ad[i] = '0; ln[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ack !== 4'b0000) begin
            errors++; $display("FAIL reset_ack: got %b want 0000", req_ack);
        end
        checks++;
        if (fsabo_valid !== 1'b0 || fsabo_addr !== 31'd0 || fsabo_len !== 3'd0 ||
            fsabo_subdid !== 4'd0 || fsabo_did !== 4'd0) begin
            errors++; $display("FAIL reset_outs: got v=%b a=%h l=%0d s=%h d=%h want all zero",
                               fsabo_valid, fsabo_addr, fsabo_len, fsabo_subdid, fsabo_did);
        end
        rv = '0;
        @(negedge clk); rst_b = 1'b1; model_reset();
    endtask

    task automatic test_single();
        int g;
        @(negedge clk); rv = 4'b0001; ad[0] = 31'h1000; ln[0] = 3'd1; rd = '0; cr = 1'b0;
        #1; model_eval(g);
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++; $display("FAIL single_ack: got %b want 0001", req_ack);
        end
        @(posedge clk); model_clock(g); #1;
        checks++;
        if (fsabo_valid !== 1'b1 || fsabo_addr !== 31'h1000 || fsabo_len !== 3'd1 ||
            fsabo_subdid !== SBASE || fsabo_did !== DID) begin
            errors++; $display("FAIL single_issue: got v=%b a=%h l=%0d s=%h want v=1 a=1000 l=1 s=%h",
                               fsabo_valid, fsabo_addr, fsabo_len, fsabo_subdid, SBASE);
        end
        @(negedge clk); rv = '0; rd = 4'b0001; cr = 1'b1;
        #1; model_eval(g);
        @(posedge clk); model_clock(g); #1;
        checks++;
        if (fsabo_valid !== 1'b0 || fsabo_addr !== 31'h1000) begin
            errors++; $display("FAIL single_hold: got v=%b a=%h want v=0 a=1000", fsabo_valid, fsabo_addr);
        end
    endtask

    task automatic test_round_robin();
        int g, p0;
        logic [3:0] prev, exp;
        p0 = m_ptr; prev = '0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rv = (k < 6) ? 4'b1111 : 4'b0000; rd = prev; cr = m_valid;
            for (int i = 0; i < 4; i++) begin ad[i] = 31'(32'h2000 + i * 16 + k); ln[i] = 3'(i + 1); end
            #1; model_eval(g);
            exp = (k < 6) ? ack_vec((p0 + 1 + k) % N) : 4'b0000;
            checks++;
            if (req_ack !== exp || req_ack !== ack_vec(g)) begin
                errors++; $display("FAIL rr_ack k=%0d: got %b want %b", k, req_ack, exp);
            end
            prev = ack_vec(g);
            @(posedge clk); model_clock(g); #1;
            checks++;
            if (!outs_ok()) begin
                errors++; $display("FAIL rr_issue k=%0d: got v=%b a=%h s=%h want v=%b a=%h s=%h",
                                   k, fsabo_valid, fsabo_addr, fsabo_subdid, m_valid, m_addr, m_sub);
            end
        end
    endtask

    task automatic test_max_outst();
        int g, n1, n2;
        n1 = 0; n2 = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            rv = (k == 6) ? 4'b0011 : 4'b0010;
            rd = (k == 6) ? 4'b0010 : 4'b0000;
            cr = m_valid;
            ad[1] = 31'(32'h3000 + k); ad[0] = 31'h0AAA;
            #1; model_eval(g);
            checks++;
            if (req_ack !== ack_vec(g)) begin
                errors++; $display("FAIL maxo_ack k=%0d: got %b want %b", k, req_ack, ack_vec(g));
            end
            if (k < 6 && req_ack[1]) n1++;
            if (k > 6 && req_ack[1]) n2++;
            if (k == 6) begin
                checks++;
                if (req_ack !== 4'b0001) begin
                    errors++; $display("FAIL maxo_compete: got %b want 0001", req_ack);
                end
            end
            @(posedge clk); model_clock(g); #1;
            checks++;
            if (!outs_ok()) begin
                errors++; $display("FAIL maxo_issue k=%0d: got v=%b s=%h want v=%b s=%h",
                                   k, fsabo_valid, fsabo_subdid, m_valid, m_sub);
            end
        end
        checks++;
        if (n1 != MAXO) begin errors++; $display("FAIL maxo_limit: got %0d grants want %0d", n1, MAXO); end
        checks++;
        if (n2 != 1) begin errors++; $display("FAIL maxo_reenable: got %0d grants want 1", n2); end
    endtask

    task automatic test_reset_mid();
        int g;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); rv = 4'b1111; rd = '0; cr = m_valid;
            #1; model_eval(g);
            @(posedge clk); model_clock(g); #1;
        end
        checks++;
        if (fsabo_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got v=%b want 1", fsabo_valid); end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (fsabo_valid !== 1'b0 || fsabo_addr !== 31'd0 || req_ack !== 4'b0000) begin
            errors++; $display("FAIL rstmid_async: got v=%b a=%h ack=%b want 0 0 0000",
                               fsabo_valid, fsabo_addr, req_ack);
        end
        rv = '0; cr = 1'b0;
        @(negedge clk); rst_b = 1'b1; model_reset();
        @(negedge clk); rv = 4'b1111;
        #1; model_eval(g);
        checks++;
        if (req_ack !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b want 0001", req_ack); end
        @(posedge clk); model_clock(g); #1;
    endtask

    task automatic test_credit_exhaust();
        int g, n, n2;
        logic [3:0] a_pulse;
        @(negedge clk); rst_b = 1'b0; rv = '0; rd = '0; cr = 1'b0;
        @(negedge clk); rst_b = 1'b1; model_reset();
        n = 0; n2 = 0; a_pulse = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); rv = 4'b1111; rd = '0; cr = (k == 8);
            #1; model_eval(g);
            checks++;
            if (req_ack !== ack_vec(g)) begin
                errors++; $display("FAIL cred_ack k=%0d: got %b want %b", k, req_ack, ack_vec(g));
            end
            if (k < 8 && req_ack != 4'b0) n++;
            if (k == 8) a_pulse = req_ack;
            if (k > 8 && req_ack != 4'b0) n2++;
            @(posedge clk); model_clock(g); #1;
            checks++;
            if (!outs_ok()) begin
                errors++; $display("FAIL cred_issue k=%0d: got v=%b s=%h want v=%b s=%h",
                                   k, fsabo_valid, fsabo_subdid, m_valid, m_sub);
            end
        end
        checks++;
        if (n != INITC) begin errors++; $display("FAIL cred_count: got %0d issues want %0d", n, INITC); end
        checks++;
        if (a_pulse !== 4'b0000 || n2 != 1) begin
            errors++; $display("FAIL cred_return: got ack_at_pulse=%b later=%0d want 0000 1", a_pulse, n2);
        end
    endtask

    task automatic test_random();
        int g;
        logic [3:0] last;
        last = '0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] || last[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ad[i] = 31'($urandom);
                    ln[i] = 3'($urandom_range(1, 7));
                end
                rd[i] = (m_outst[i] > 0) && ($urandom_range(0, 2) == 0);
            end
            cr = (m_cred - (m_valid ? 1 : 0) < INITC) && ($urandom_range(0, 1) == 1);
            #1; model_eval(g);
            checks++;
            if (req_ack !== ack_vec(g)) begin
                errors++; $display("FAIL rand_ack k=%0d: got %b want %b", k, req_ack, ack_vec(g));
            end
            last = ack_vec(g);
            @(posedge clk); model_clock(g); #1;
            checks++;
            if (!outs_ok()) begin
                errors++; $display("FAIL rand_issue k=%0d: got v=%b a=%h l=%0d s=%h want v=%b a=%h l=%0d s=%h",
                                   k, fsabo_valid, fsabo_addr, fsabo_len, fsabo_subdid,
                                   m_valid, m_addr, m_len, m_sub);
            end
        end
    endtask

`ifdef FSAB_ARB_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stat_grants[i*16 +: 16] !== 16'(m_sg[i]) || stat_stalls[i*16 +: 16] !== 16'(m_ss[i])) begin
                errors++; $display("FAIL stats_%0d: got g=%0d s=%0d want g=%0d s=%0d", i,
                                   stat_grants[i*16 +: 16], stat_stalls[i*16 +: 16], m_sg[i], m_ss[i]);
            end
        end
        @(negedge clk); rst_b = 1'b0; rv = '0; rd = '0; cr = 1'b0;
        @(negedge clk); rst_b = 1'b1; model_reset();
        @(negedge clk); rv = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stat_stalls[15:0] !== 16'hFFFF || stat_grants[15:0] !== 16'(MAXO) ||
            stat_stalls[63:16] !== 48'd0) begin
            errors++; $display("FAIL stats_sat: got s0=%h g0=%0d rest=%h want FFFF %0d 0",
                               stat_stalls[15:0], stat_grants[15:0], stat_stalls[63:16], MAXO);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_outst();
        test_reset_mid();
        test_credit_exhaust();
        test_random();
`ifdef FSAB_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsab_dma_arbiter.md
Name: fsab_dma_arbiter

Overview:
- Shares one FSAB request port among N_REQ DMA read engines (display scanout, audio, preload).
- Arbitrates round-robin and owns the FSAB credit counter.
- Enforces a per-requester outstanding-request limit.
- Tags each request with subdid = requester index, so response demux on fsabi is a pure subdid compare downstream.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FSAB_DID, 4'hF, device ID driven on every request; must be overridden.
- SUBDID_BASE, 4'h0, subdid of requester i is SUBDID_BASE+i.
- MAX_OUTST, 2, maximum outstanding reads per requester (1..7).

Ports:
- clk  in  1  system clock.
- rst_b  in  1  reset.
- req_valid  in  N_REQ  requester i wants to issue a read.
- req_addr  in  N_REQ*(FSAB_ADDR_HI+1)  per-requester read address; slice i.
- req_len  in  N_REQ*(FSAB_LEN_HI+1)  per-requester read length in 8-byte beats.
- req_ack  out  N_REQ  one-hot; request i accepted this cycle.
- req_done  in  N_REQ  pulse from requester i when its final response beat has arrived.
- fsabo_valid  out  1  FSAB request strobe.
- fsabo_mode  out  FSAB_REQ_HI+1  always FSAB_READ when valid.
- fsabo_did  out  FSAB_DID_HI+1  FSAB device ID.
- fsabo_subdid  out  FSAB_DID_HI+1  requester tag.
- fsabo_addr  out  FSAB_ADDR_HI+1  request address.
- fsabo_len  out  FSAB_LEN_HI+1  request length.
- fsabo_credit  in  1  credit return from FSAB.

Behaviour:
- Reset: rst_b is asynchronous, active-low; clock is clk.
- Reset values: fsabo_valid=0, fsabo_* data=0, req_ack=0, credits=FSAB_INITIAL_CREDITS, rr pointer=N_REQ-1, all outstanding counters=0.
- Eligibility: requester i is eligible iff req_valid[i] && outst[i] < MAX_OUTST.
- Credit gate: cred_ok = credits > (fsabo_valid ? 1 : 0).
- Grant cycle N: if cred_ok and any requester is eligible, grant the first eligible index searching from rr_ptr+1 upward with wrap.
  - req_ack[grant] is combinational and asserted in cycle N.
  - rr_ptr <= grant.
  - outst[grant]++.
- Issue cycle N+1: fsabo_valid=1 with the registered slice of the granted requester; subdid=SUBDID_BASE+grant.
  - At most one issue per cycle; back-to-back issues are allowed.
  - When fsabo_valid=0, the data outputs hold their last values.
- Requester handshake: hold addr/len stable while req_valid is high until the ack edge; new values are permitted in the cycle after ack.
- Credit counter update: credits <= credits + fsabo_credit - fsabo_valid.
  - Simultaneous +1/-1 leaves it unchanged.
  - Underflow must be impossible by construction (assertion).
  - Overflow beyond FSAB_INITIAL_CREDITS is flagged by an assertion.
- Outstanding counters:
  - Grant and req_done on the same requester in the same cycle leave outst unchanged.
  - req_done with outst=0 is ignored (assertion fires).
- Starvation bound: any continuously eligible requester is granted within N_REQ grants.
- Reset mid-operation: all requests in flight are forgotten. Requesters are reset by the same rst_b.

Optional Feature:
- FSAB_ARB_STATS_EN defined: adds outputs stat_grants (N_REQ*16) and stat_stalls (N_REQ*16).
  - stat_grants[i] increments on each grant to requester i.
  - stat_stalls[i] increments each cycle requester i has req_valid=1 but is not granted.
  - Both counters are saturating, reset to 0, and read-only.
- Undefined: the stat ports and counters are absent. Arbitration timing is identical either way.

Decomposition:
- Shared package (fsab_defines.vh): FSAB_* widths, FSAB_READ, FSAB_INITIAL_CREDITS, FSAB_CREDITS_HI.
- Local constant: clog2 of N_REQ for rr_ptr width.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs: eligible vector, rr_ptr. Outputs: one-hot grant, index, any.
- Credit and outstanding logic stays in the top module.

Test Plan:
- Single requester 0: req_valid=1, addr=0x1000, len=1. Expect req_ack[0] in cycle N, then fsabo_valid at N+1 with addr=0x1000, subdid=SUBDID_BASE. outst[0]=1.
- All 4 requesters valid continuously, credits ample, MAX_OUTST=7, req_done asserted after each grant. Expect grant order 0,1,2,3,0,1 with one grant per cycle.
- Credit exhaustion: FSAB_INITIAL_CREDITS=2, no fsabo_credit returned. Expect exactly 2 issues then stall. Pulse fsabo_credit once: exactly one further issue, not before the cycle after the credit.
- MAX_OUTST=2, requester 1 always valid, no req_done. Expect 2 grants then no ack. A req_done pulse in the same cycle as a competing grant re-enables exactly one more grant.
- Assert rst_b low during back-to-back issue. Expect fsabo_valid=0 and credits=FSAB_INITIAL_CREDITS immediately (asynchronous), and the first grant to go to requester 0 after release.
- With FSAB_ARB_STATS_EN: requester 2 valid and blocked by requester 3 for 5 cycles. Expect stat_stalls[2]=5 and stat_grants[3] equal to its grant count. Run 70000 cycles and confirm the counters saturate at 0xFFFF.
